// File: rtl/rv_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit.
package rv_ctrl_pkg;

   localparam int unsigned OPW = 7;

   typedef enum logic [3:0] {
      StFetch,
      StDecode,
      StMemAdr,
      StMemRead,
      StMemWb,
      StMemWrite,
      StExecR,
      StExecI,
      StAluWb,
      StBranch,
      StJal
   } state_e;

   // Opcodes handled by this core
   localparam logic [OPW-1:0] OPC_LOAD   = 7'b0000011;
   localparam logic [OPW-1:0] OPC_STORE  = 7'b0100011;
   localparam logic [OPW-1:0] OPC_OP     = 7'b0110011;
   localparam logic [OPW-1:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [OPW-1:0] OPC_BRANCH = 7'b1100011;
   localparam logic [OPW-1:0] OPC_JAL    = 7'b1101111;

   // ALU operation codes
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLL = 3'b100;
   localparam logic [2:0] ALU_SRL = 3'b101;
   localparam logic [2:0] ALU_SRA = 3'b110;
   localparam logic [2:0] ALU_XOR = 3'b111;

   // Requests from the FSM to the ALU decoder
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // Datapath mux selects
   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_MEM    = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_REGA  = 2'b10;

   localparam logic [1:0] SRCB_REGB  = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decode from the FSM request and funct fields.
module alu_decoder
   import rv_ctrl_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       is_rtype,
   output logic [2:0] alu_ctrl,
   output logic       unsupported
);

   // Map alu_op/funct3/funct7b5 onto the ALU encoding; SLT/SLTU are flagged
   always_comb begin
      alu_ctrl    = ALU_ADD;
      unsupported = 1'b0;
      case (alu_op)
         ALUOP_SUB: alu_ctrl = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               3'b000:  alu_ctrl = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
               3'b001:  alu_ctrl = ALU_SLL;
               3'b100:  alu_ctrl = ALU_XOR;
               3'b101:  alu_ctrl = funct7b5 ? ALU_SRA : ALU_SRL;
               3'b110:  alu_ctrl = ALU_OR;
               3'b111:  alu_ctrl = ALU_AND;
               default: unsupported = 1'b1;
            endcase
         end
         default: alu_ctrl = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: sequences fetch/decode/execute and drives datapath controls.
module multicycle_ctrl
   import rv_ctrl_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   input  logic [OPW-1:0] opcode,
   input  logic [2:0]     funct3,
   input  logic           funct7b5,
   input  logic           zero,
   input  logic           mem_ready,
   output logic           pc_write,
   output logic           adr_src,
   output logic           mem_write,
   output logic           ir_write,
   output logic [1:0]     result_src,
   output logic [1:0]     alu_src_a,
   output logic [1:0]     alu_src_b,
   output logic [1:0]     imm_src,
   output logic           reg_write,
   output logic [2:0]     alu_ctrl,
   output logic           illegal_instr
);

   state_e     state_q, state_d;
   logic [1:0] alu_op;
   logic       unsupported;
   logic       is_rtype;
   logic       pc_write_raw, mem_write_raw, ir_write_raw, reg_write_raw, illegal_raw;

   assign is_rtype = (opcode == OPC_OP);

   alu_decoder u_alu_decoder (
      .alu_op      (alu_op),
      .funct3      (funct3),
      .funct7b5    (funct7b5),
      .is_rtype    (is_rtype),
      .alu_ctrl    (alu_ctrl),
      .unsupported (unsupported)
   );

   // State register, asynchronously returned to FETCH
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StFetch;
      else        state_q <= state_d;
   end

   // Immediate format follows the opcode held in the IR
   always_comb begin
      imm_src = IMM_I;
      case (opcode)
         OPC_STORE:  imm_src = IMM_S;
         OPC_BRANCH: imm_src = IMM_B;
         OPC_JAL:    imm_src = IMM_J;
         default:    imm_src = IMM_I;
      endcase
   end

   // Next-state and per-state control outputs
   always_comb begin
      state_d       = state_q;
      adr_src       = 1'b0;
      result_src    = RES_ALUOUT;
      alu_src_a     = SRCA_PC;
      alu_src_b     = SRCB_REGB;
      alu_op        = ALUOP_ADD;
      pc_write_raw  = 1'b0;
      mem_write_raw = 1'b0;
      ir_write_raw  = 1'b0;
      reg_write_raw = 1'b0;
      illegal_raw   = 1'b0;
      unique case (state_q)
         StFetch: begin
            alu_src_b    = SRCB_FOUR;
            result_src   = RES_ALU;
            ir_write_raw = mem_ready;
            pc_write_raw = mem_ready;
            if (mem_ready) state_d = StDecode;
         end
         StDecode: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            case (opcode)
               OPC_LOAD, OPC_STORE: state_d = StMemAdr;
               OPC_OP:              state_d = StExecR;
               OPC_OP_IMM:          state_d = StExecI;
               OPC_BRANCH:          state_d = StBranch;
               OPC_JAL:             state_d = StJal;
               default: begin
                  illegal_raw = 1'b1;
                  state_d     = StFetch;
               end
            endcase
         end
         StMemAdr: begin
            alu_src_a = SRCA_REGA;
            alu_src_b = SRCB_IMM;
            state_d   = (opcode == OPC_STORE) ? StMemWrite : StMemRead;
         end
         StMemRead: begin
            adr_src = 1'b1;
            if (mem_ready) state_d = StMemWb;
         end
         StMemWb: begin
            result_src    = RES_MEM;
            reg_write_raw = 1'b1;
            state_d       = StFetch;
         end
         StMemWrite: begin
            adr_src       = 1'b1;
            mem_write_raw = 1'b1;
            if (mem_ready) state_d = StFetch;
         end
         StExecR, StExecI: begin
            alu_src_a   = SRCA_REGA;
            alu_src_b   = (state_q == StExecI) ? SRCB_IMM : SRCB_REGB;
            alu_op      = ALUOP_FUNCT;
            illegal_raw = unsupported;
            state_d     = StAluWb;
         end
         StAluWb: begin
            // Re-decode funct so an unsupported op never reaches the register file
            if (opcode == OPC_OP || opcode == OPC_OP_IMM) alu_op = ALUOP_FUNCT;
            reg_write_raw = ~unsupported;
            state_d       = StFetch;
         end
         StBranch: begin
            alu_src_a = SRCA_REGA;
            alu_op    = ALUOP_SUB;
            if (funct3[2:1] == 2'b00) pc_write_raw = zero ^ funct3[0];
            else                      illegal_raw  = 1'b1;
            state_d = StFetch;
         end
         StJal: begin
            alu_src_a    = SRCA_OLDPC;
            alu_src_b    = SRCB_FOUR;
            pc_write_raw = 1'b1;
            state_d      = StAluWb;
         end
         default: state_d = StFetch;
      endcase
   end

   // Enables are suppressed for as long as reset is held
   assign pc_write      = pc_write_raw  & rst_n;
   assign mem_write     = mem_write_raw & rst_n;
   assign ir_write      = ir_write_raw  & rst_n;
   assign reg_write     = reg_write_raw & rst_n;
   assign illegal_instr = illegal_raw   & rst_n;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl.
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] opcode = 7'b0;
   logic [2:0] funct3 = 3'b0;
   logic       funct7b5 = 1'b0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
   logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
   logic [2:0] alu_ctrl;

   int checks = 0;
   int failures = 0;

   multicycle_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .opcode        (opcode),
      .funct3        (funct3),
      .funct7b5      (funct7b5),
      .zero          (zero),
      .mem_ready     (mem_ready),
      .pc_write      (pc_write),
      .adr_src       (adr_src),
      .mem_write     (mem_write),
      .ir_write      (ir_write),
      .result_src    (result_src),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .imm_src       (imm_src),
      .reg_write     (reg_write),
      .alu_ctrl      (alu_ctrl),
      .illegal_instr (illegal_instr)
   );

   always #5 clk = ~clk;

   wire [14:0] outv = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                       alu_src_b, reg_write, alu_ctrl, illegal_instr};

   task automatic check(input string tag, input logic [14:0] obs, input logic [14:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b", tag, obs, exp);
      end
   endtask

   // {pc, adr, mw, ir, res, a, b, rw, alu, ill}
   function automatic logic [14:0] ev(input logic pc, input logic adr, input logic mw,
                                      input logic ir, input logic [1:0] res,
                                      input logic [1:0] a, input logic [1:0] b,
                                      input logic rw, input logic [2:0] alu,
                                      input logic ill);
      return {pc, adr, mw, ir, res, a, b, rw, alu, ill};
   endfunction

   // Drive one cycle of inputs, check outputs mid-cycle, advance past the next edge
   task automatic cyc(input string tag, input logic mr, input logic z, input logic [14:0] e);
      mem_ready = mr;
      zero      = z;
      @(negedge clk);
      check(tag, outv, e);
      @(posedge clk);
      #1;
   endtask

   task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
      opcode   = op;
      funct3   = f3;
      funct7b5 = f7;
   endtask

   localparam logic [14:0] FetchRdy  = 15'b1_0_0_1_10_00_10_0_000_0;
   localparam logic [14:0] FetchIdle = 15'b0_0_0_0_10_00_10_0_000_0;
   localparam logic [14:0] Decode    = 15'b0_0_0_0_00_01_01_0_000_0;

   initial begin
      // Test 1: reset and idle fetch
      mem_ready = 1'b1;
      #2;
      check("reset_enables", outv, FetchIdle);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) cyc("fetch_wait", 1'b0, 1'b0, FetchIdle);

      // Test 2: lw with two wait cycles
      set_instr(7'b0000011, 3'b010, 1'b0);
      cyc("lw_fetch", 1'b1, 1'b0, FetchRdy);
      mem_ready = 1'b0;
      @(negedge clk);
      check("lw_imm_src", {13'b0, imm_src}, 15'd0);
      @(posedge clk);
      #1;
      cyc("lw_memadr", 1'b0, 1'b0, ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 3'b000, 0));
      cyc("lw_memrd0", 1'b0, 1'b0, ev(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 3'b000, 0));
      cyc("lw_memrd1", 1'b0, 1'b0, ev(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 3'b000, 0));
      cyc("lw_memrd2", 1'b1, 1'b0, ev(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 3'b000, 0));
      cyc("lw_memwb", 1'b1, 1'b0, ev(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 1, 3'b000, 0));

      // Test 3: R-type SUB
      set_instr(7'b0110011, 3'b000, 1'b1);
      cyc("sub_fetch", 1'b1, 1'b0, FetchRdy);
      cyc("sub_decode", 1'b0, 1'b0, Decode);
      cyc("sub_execr", 1'b0, 1'b0, ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 3'b001, 0));
      cyc("sub_aluwb", 1'b0, 1'b0, ev(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 3'b001, 0));
      // OP-IMM SRAI / SRLI / ADDI with funct7b5 set (must stay ADD)
      set_instr(7'b0010011, 3'b101, 1'b1);
      cyc("srai_fetch", 1'b1, 1'b0, FetchRdy);
      cyc("srai_decode", 1'b0, 1'b0, Decode);
      cyc("srai_execi", 1'b0, 1'b0, ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 3'b110, 0));
      cyc("srai_aluwb", 1'b0, 1'b0, ev(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 3'b110, 0));
      set_instr(7'b0010011, 3'b101, 1'b0);
      cyc("srli_fetch", 1'b1, 1'b0, FetchRdy);
      cyc("srli_decode", 1'b0, 1'b0, Decode);
      cyc("srli_execi", 1'b0, 1'b0, ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 3'b101, 0));
      cyc("srli_aluwb", 1'b0, 1'b0, ev(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 3'b101, 0));
      set_instr(7'b0010011, 3'b000, 1'b1);
      cyc("addi_fetch", 1'b1, 1'b0, FetchRdy);
      cyc("addi_decode", 1'b0, 1'b0, Decode);
      cyc("addi_execi", 1'b0, 1'b0, ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 3'b000, 0));
      cyc("addi_aluwb", 1'b0, 1'b0, ev(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 3'b000, 0));

      // Test 4: branches
      set_instr(7'b1100011, 3'b000, 1'b0);
      cyc("beq1_fetch", 1'b1, 1'b0, FetchRdy);
      mem_ready = 1'b0;
      @(negedge clk);
      check("beq_imm_src", {13'b0, imm_src}, 15'd2);
      @(posedge clk);
      #1;
      cyc("beq1_branch", 1'b0, 1'b1, ev(1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 3'b001, 0));
      cyc("beq0_fetch", 1'b1, 1'b0, FetchRdy);
      cyc("beq0_decode", 1'b0, 1'b0, Decode);
      cyc("beq0_branch", 1'b0, 1'b0, ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 3'b001, 0));
      set_instr(7'b1100011, 3'b001, 1'b0);
      cyc("bne_fetch", 1'b1, 1'b0, FetchRdy);
      cyc("bne_decode", 1'b0, 1'b0, Decode);
      cyc("bne_branch", 1'b0, 1'b0, ev(1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 3'b001, 0));
      set_instr(7'b1100011, 3'b100, 1'b0);
      cyc("blt_fetch", 1'b1, 1'b0, FetchRdy);
      cyc("blt_decode", 1'b0, 1'b0, Decode);
      cyc("blt_branch", 1'b0, 1'b0, ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 3'b001, 1));

      // Test 5: SLT unsupported, then unknown opcode
      set_instr(7'b0110011, 3'b010, 1'b0);
      cyc("slt_fetch", 1'b1, 1'b0, FetchRdy);
      cyc("slt_decode", 1'b0, 1'b0, Decode);
      cyc("slt_execr", 1'b0, 1'b0, ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 3'b000, 1));
      cyc("slt_aluwb", 1'b0, 1'b0, ev(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 3'b000, 0));
      cyc("slt_refetch", 1'b0, 1'b0, FetchIdle);
      set_instr(7'b0000000, 3'b000, 1'b0);
      cyc("ill_fetch", 1'b1, 1'b0, FetchRdy);
      cyc("ill_decode", 1'b0, 1'b0, ev(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, 3'b000, 1));
      cyc("ill_refetch", 1'b0, 1'b0, FetchIdle);

      // Test 6a: sw completing after one wait cycle, held ready must not rewrite
      set_instr(7'b0100011, 3'b010, 1'b0);
      cyc("sw_fetch", 1'b1, 1'b0, FetchRdy);
      mem_ready = 1'b0;
      @(negedge clk);
      check("sw_imm_src", {13'b0, imm_src}, 15'd1);
      @(posedge clk);
      #1;
      cyc("sw_memadr", 1'b0, 1'b0, ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 3'b000, 0));
      cyc("sw_wait", 1'b0, 1'b0, ev(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 3'b000, 0));
      cyc("sw_done", 1'b1, 1'b0, ev(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 3'b000, 0));
      cyc("sw_after", 1'b1, 1'b0, FetchRdy);
      // Test 6b: reset asserted while a store is waiting
      cyc("swr_decode", 1'b0, 1'b0, Decode);
      cyc("swr_memadr", 1'b0, 1'b0, ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 3'b000, 0));
      mem_ready = 1'b0;
      @(negedge clk);
      check("swr_memwrite", outv, ev(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 3'b000, 0));
      #1;
      rst_n = 1'b0;
      #1;
      check("swr_async_drop", outv, FetchIdle);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc("swr_refetch", 1'b0, 1'b0, FetchIdle);

      // Test 6c: jal
      set_instr(7'b1101111, 3'b000, 1'b0);
      cyc("jal_fetch", 1'b1, 1'b0, FetchRdy);
      mem_ready = 1'b0;
      @(negedge clk);
      check("jal_imm_src", {13'b0, imm_src}, 15'd3);
      @(posedge clk);
      #1;
      cyc("jal_jal", 1'b0, 1'b0, ev(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 0, 3'b000, 0));
      cyc("jal_aluwb", 1'b0, 1'b0, ev(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 3'b000, 0));
      cyc("jal_refetch", 1'b0, 1'b0, FetchIdle);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control FSM for the RV32I core. It decodes opcode/funct fields and drives datapath selects, write enables and the 3-bit alu_ctrl into the ALU, and consumes the ALU zero flag for branches. Memory accesses use a single-port memory with a ready handshake. It sits between the instruction register and the shared datapath.

Parameters:
OPW, 7, opcode width (fixed by ISA; parameterised for the package constants only)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  async active-low reset
opcode  in  7  instr[6:0] from IR
funct3  in  3  instr[14:12]
funct7b5  in  1  instr[30]
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the access this cycle
pc_write  out  1  PC register enable
adr_src  out  1  0=PC, 1=ALUOut onto memory address
mem_write  out  1  memory write strobe
ir_write  out  1  IR/oldPC enable
result_src  out  2  00=ALUOut, 01=mem data, 10=ALU result
alu_src_a  out  2  00=PC, 01=oldPC, 10=regA
alu_src_b  out  2  00=regB, 01=imm, 10=const 4
imm_src  out  2  00=I, 01=S, 10=B, 11=J
reg_write  out  1  register file write enable
alu_ctrl  out  3  000 ADD,001 SUB,010 AND,011 OR,100 SLL,101 SRL,110 SRA,111 XOR
illegal_instr  out  1  one-cycle pulse on an unsupported instruction

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL. State register is the only sequential element. Outputs are combinational from state, plus mem_ready/zero where noted.
- Reset (rst_n=0, asynchronous): state=FETCH. All enables (pc_write, ir_write, mem_write, reg_write, illegal_instr) are forced 0 while rst_n=0. Mux selects take FETCH values.
- FETCH: adr_src=0, a=00, b=10, ADD, result_src=10. ir_write=pc_write=mem_ready. Stay in FETCH until mem_ready=1, then go to DECODE.
- DECODE: a=01, b=01, ADD (branch target into ALUOut). imm_src is set per opcode. Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - other -> FETCH with illegal_instr=1
- MEMADR: a=10, b=01, ADD. lw -> MEMREAD, sw -> MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. Wait for mem_ready, then go to MEMWB.
- MEMWB: result_src=01, reg_write=1, then FETCH.
- MEMWRITE: adr_src=1, result_src=00, mem_write=1 held until the cycle mem_ready=1, then FETCH.
- EXECR: a=10, b=00. EXECI: a=10, b=01. Both use funct decode and go to ALUWB.
- ALUWB: result_src=00, reg_write=1, then FETCH.
- BRANCH: a=10, b=00, SUB, result_src=00. pc_write = zero XOR funct3[0] (000 BEQ, 001 BNE). Other funct3 values pulse illegal_instr with pc_write=0. Then FETCH.
- JAL: a=01, b=10, ADD, result_src=00, pc_write=1, then ALUWB (rd=PC+4).
- imm_src per opcode: I for lw/OP-IMM, S for sw, B for branch, J for jal.
- Funct decode (EXECR/EXECI):
  - 000: ADD; SUB only if R-type and funct7b5=1. OP-IMM ignores funct7b5 here.
  - 001: SLL. 100: XOR. 110: OR. 111: AND.
  - 101: SRA if funct7b5 else SRL, for both R and I.
  - 010/011 (SLT/SLTU) are unsupported: pulse illegal_instr, reg_write suppressed in the following ALUWB, so the architectural state is unchanged.
- Only one enable sequence per instruction. No write is issued twice even if mem_ready stays high.
- rst_n falling mid-instruction aborts immediately: any pending MEMWRITE or reg_write is dropped and the FSM restarts at FETCH.

Decomposition:
- Package rv_ctrl_pkg holds:
  - state enum (4-bit)
  - opcode constants
  - ALU_ADD..ALU_XOR 3-bit codes matching the ALU encoding above
  - mux select constants for result/src_a/src_b/imm_src
- Sub-module alu_decoder (combinational): inputs alu_op[1:0] (00 add, 01 sub, 10 funct), funct3, funct7b5, is_rtype. Outputs alu_ctrl and unsupported.

Test Plan:
1. Reset with rst_n=0, then release with mem_ready=0 for 3 cycles -> state stays FETCH with all enables 0. mem_ready=1 -> ir_write=pc_write=1 for exactly one cycle, then DECODE.
2. lw (0000011) with 2 wait cycles in MEMREAD -> FETCH, DECODE, MEMADR (alu_ctrl=000), MEMREAD x3, MEMWB with reg_write=1 and result_src=01. Total 7 cycles with mem_ready high in FETCH.
3. R-type funct3=000 funct7b5=1 -> EXECR alu_ctrl=001. OP-IMM funct3=101 funct7b5=1 -> alu_ctrl=110. funct3=101 funct7b5=0 -> 101. ALUWB reg_write=1.
4. BEQ with zero=1 -> pc_write=1 in BRANCH. BEQ zero=0 -> 0. BNE zero=0 -> 1. alu_ctrl=001 throughout.
5. Opcode 0110011 funct3=010 -> illegal_instr pulses once, no reg_write, back to FETCH. Opcode 0000000 -> illegal_instr in DECODE, next state FETCH.
6. sw with rst_n asserted low in MEMWRITE before mem_ready -> mem_write drops asynchronously, no write completes, FETCH after release. jal -> pc_write in JAL, then reg_write in ALUWB.
